// File: rtl/scope_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
// scope_cmd_ctrl_if : UART byte-stream bundle (rx strobe in, tx reply out)
// Rev 1.0
// ============================================================================
interface scope_cmd_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output rx_valid, rx_data, tx_ready, input tx_valid, tx_data);
  modport slave  (input rx_valid, rx_data, tx_ready, output tx_valid, tx_data);
endinterface
`default_nettype wire

// File: rtl/scope_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// scope_cmd_ctrl : UART opcode/payload sequencer loading scope trigger config
// Rev 1.0
// ============================================================================
module scope_cmd_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int PAYLOAD_BYTES  = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  scope_cmd_ctrl_if.slave        uart,
  input  logic                   scope_busy,
  input  logic                   scope_triggered,
  input  logic                   scope_done,
  output logic                   arm,
  output logic                   abort,
  output logic                   cfg_update,
  output logic                   cfg_edge,
  output logic [15:0]            cfg_level,
  output logic [31:0]            cfg_pretrig,
  output logic [31:0]            cfg_posttrig
);

  localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int            SW        = PAYLOAD_BYTES * 8;
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    IDX_LAST  = 4'(PAYLOAD_BYTES - 1);
  localparam logic [7:0]    ACK       = 8'h06;
  localparam logic [7:0]    NAK       = 8'h15;
  localparam logic [7:0]    OP_ARM    = 8'h41;
  localparam logic [7:0]    OP_RISE   = 8'h52;
  localparam logic [7:0]    OP_FALL   = 8'h46;
  localparam logic [7:0]    OP_ABORT  = 8'h58;
  localparam logic [7:0]    OP_STATUS = 8'h53;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PAYLOAD = 2'd1, S_RESP = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            edge_sh_q, edge_sh_d;
  logic [SW-1:0]   shadow_q, shadow_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            arm_q, arm_d, abort_q, abort_d, cfg_update_q, cfg_update_d;
  logic            cfg_edge_q, cfg_edge_d;
  logic [15:0]     cfg_level_q, cfg_level_d;
  logic [31:0]     cfg_pretrig_q, cfg_pretrig_d, cfg_posttrig_q, cfg_posttrig_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      tmo_q          <= '0;
      edge_sh_q      <= 1'b1;
      shadow_q       <= '0;
      tx_valid_q     <= 1'b0;
      tx_data_q      <= 8'h00;
      arm_q          <= 1'b0;
      abort_q        <= 1'b0;
      cfg_update_q   <= 1'b0;
      cfg_edge_q     <= 1'b1;
      cfg_level_q    <= 16'h2000;
      cfg_pretrig_q  <= 32'd0;
      cfg_posttrig_q <= 32'd1024;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      tmo_q          <= tmo_d;
      edge_sh_q      <= edge_sh_d;
      shadow_q       <= shadow_d;
      tx_valid_q     <= tx_valid_d;
      tx_data_q      <= tx_data_d;
      arm_q          <= arm_d;
      abort_q        <= abort_d;
      cfg_update_q   <= cfg_update_d;
      cfg_edge_q     <= cfg_edge_d;
      cfg_level_q    <= cfg_level_d;
      cfg_pretrig_q  <= cfg_pretrig_d;
      cfg_posttrig_q <= cfg_posttrig_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    tmo_d          = tmo_q;
    edge_sh_d      = edge_sh_q;
    shadow_d       = shadow_q;
    tx_valid_d     = tx_valid_q;
    tx_data_d      = tx_data_q;
    arm_d          = 1'b0;
    abort_d        = 1'b0;
    cfg_update_d   = 1'b0;
    cfg_edge_d     = cfg_edge_q;
    cfg_level_d    = cfg_level_q;
    cfg_pretrig_d  = cfg_pretrig_q;
    cfg_posttrig_d = cfg_posttrig_q;

    unique case (state_q)
      S_IDLE: begin
        if (uart.rx_valid) begin
          state_d    = S_RESP;
          tx_valid_d = 1'b1;
          tx_data_d  = NAK;
          case (uart.rx_data)
            OP_ARM: begin
              if (!scope_busy) begin
                arm_d     = 1'b1;
                tx_data_d = ACK;
              end
            end
            OP_RISE, OP_FALL: begin
              state_d    = S_PAYLOAD;
              tx_valid_d = 1'b0;
              tx_data_d  = tx_data_q;
              idx_d      = '0;
              tmo_d      = TMO_ONE;
              edge_sh_d  = (uart.rx_data == OP_RISE);
            end
            OP_ABORT: begin
              abort_d   = 1'b1;
              tx_data_d = ACK;
            end
            OP_STATUS: tx_data_d = {5'b0, scope_done, scope_triggered, scope_busy};
            default: ;
          endcase
        end
      end
      S_PAYLOAD: begin
        if (uart.rx_valid) begin
          shadow_d[{idx_q, 3'b000} +: 8] = uart.rx_data;
          idx_d = idx_q + 4'd1;
          tmo_d = TMO_ONE;
          if (idx_q == IDX_LAST) begin
            // Last byte is merged combinationally so cfg_* can load in the same edge.
            state_d    = S_RESP;
            idx_d      = '0;
            tx_valid_d = 1'b1;
            tx_data_d  = NAK;
            if (!scope_busy) begin
              tx_data_d      = ACK;
              cfg_update_d   = 1'b1;
              cfg_edge_d     = edge_sh_q;
              cfg_level_d    = shadow_d[15:0];
              cfg_pretrig_d  = shadow_d[47:16];
              cfg_posttrig_d = shadow_d[79:48];
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d    = S_RESP;
          idx_d      = '0;
          shadow_d   = '0;
          tx_valid_d = 1'b1;
          tx_data_d  = NAK;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      S_RESP: begin
        if (uart.tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign uart.tx_valid = tx_valid_q;
  assign uart.tx_data  = tx_data_q;
  assign arm           = arm_q;
  assign abort         = abort_q;
  assign cfg_update    = cfg_update_q;
  assign cfg_edge      = cfg_edge_q;
  assign cfg_level     = cfg_level_q;
  assign cfg_pretrig   = cfg_pretrig_q;
  assign cfg_posttrig  = cfg_posttrig_q;

endmodule
`default_nettype wire

// File: tb/tb_scope_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// tb_scope_cmd_ctrl : vector table, corner sequences and random commands
// Rev 1.0
// ============================================================================
module tb_scope_cmd_ctrl;
  localparam int         TMO = 100;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic        clk = 1'b0;
  logic        rst;
  logic        scope_busy, scope_triggered, scope_done;
  logic        arm, abort, cfg_update, cfg_edge;
  logic [15:0] cfg_level;
  logic [31:0] cfg_pretrig, cfg_posttrig;

  int n_cmp = 0;
  int n_bad = 0;

  logic        ref_edge;
  logic [15:0] ref_level;
  logic [31:0] ref_pre, ref_post;

  typedef struct packed {
    logic [7:0] op;
    logic       busy, trig, done;
    logic [7:0] reply;
    logic       exp_arm, exp_abort;
  } vec_t;

  vec_t       vecs [10];
  logic [7:0] pl [10];
  int         cnt;

  scope_cmd_ctrl_if uart_if ();

  scope_cmd_ctrl #(.TIMEOUT_CYCLES(TMO), .PAYLOAD_BYTES(10)) dut (
    .clk(clk), .rst(rst), .uart(uart_if),
    .scope_busy(scope_busy), .scope_triggered(scope_triggered), .scope_done(scope_done),
    .arm(arm), .abort(abort), .cfg_update(cfg_update), .cfg_edge(cfg_edge),
    .cfg_level(cfg_level), .cfg_pretrig(cfg_pretrig), .cfg_posttrig(cfg_posttrig)
  );

  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    uart_if.rx_valid = 1'b1;
    uart_if.rx_data  = b;
    tick();
    uart_if.rx_valid = 1'b0;
  endtask

  task automatic ref_reset();
    ref_edge  = 1'b1;
    ref_level = 16'h2000;
    ref_pre   = 32'd0;
    ref_post  = 32'd1024;
  endtask

  task automatic chk_cfg(input string name);
    chk({name, ".edge"},  32'(cfg_edge),     32'(ref_edge));
    chk({name, ".level"}, 32'(cfg_level),    32'(ref_level));
    chk({name, ".pre"},   cfg_pretrig,       ref_pre);
    chk({name, ".post"},  cfg_posttrig,      ref_post);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, ".tx_valid"}, 32'(uart_if.tx_valid), 0);
    chk({name, ".tx_data"},  32'(uart_if.tx_data),  0);
    chk({name, ".strobes"},  32'({arm, abort, cfg_update}), 0);
    chk_cfg(name);
  endtask

  function automatic logic [7:0] ref_reply(input logic [7:0] op, input logic busy,
                                           input logic trig, input logic done);
    case (op)
      8'h41:   return busy ? NAK : ACK;
      8'h58:   return ACK;
      8'h53:   return {5'b0, done, trig, busy};
      default: return NAK;
    endcase
  endfunction

  // One-byte command: reply, strobes in the cycle after the opcode, then IDLE.
  task automatic single_cmd(input string name, input logic [7:0] op, input logic busy,
                            input logic trig, input logic done, input logic [7:0] reply,
                            input logic e_arm, input logic e_abort);
    scope_busy = busy; scope_triggered = trig; scope_done = done;
    send(op);
    chk({name, ".tx_valid"}, 32'(uart_if.tx_valid), 1);
    chk({name, ".tx_data"},  32'(uart_if.tx_data),  32'(reply));
    chk({name, ".arm"},      32'(arm),              32'(e_arm));
    chk({name, ".abort"},    32'(abort),            32'(e_abort));
    tick();
    chk({name, ".idle"},     32'({uart_if.tx_valid, arm, abort}), 0);
  endtask

  // Trigger-config command: op, ten payload bytes with random gaps, busy at byte 9.
  task automatic cfg_cmd(input string name, input logic [7:0] op, input logic busy_last,
                         input int max_gap);
    logic [7:0] reply;
    scope_busy = 1'b0;
    send(op);
    chk({name, ".no_reply"}, 32'(uart_if.tx_valid), 0);
    for (int i = 0; i < 10; i++) begin
      for (int g = $urandom_range(0, max_gap); g > 0; g--) tick();
      scope_busy = (i == 9) ? busy_last : 1'($urandom_range(0, 1));
      send(pl[i]);
    end
    reply = NAK;
    if (!busy_last) begin
      reply     = ACK;
      ref_edge  = (op == 8'h52);
      ref_level = 16'(pl[0]) + (16'(pl[1]) << 8);
      ref_pre   = 32'(pl[2]) + (32'(pl[3]) << 8) + (32'(pl[4]) << 16) + (32'(pl[5]) << 24);
      ref_post  = 32'(pl[6]) + (32'(pl[7]) << 8) + (32'(pl[8]) << 16) + (32'(pl[9]) << 24);
    end
    chk({name, ".tx_valid"},   32'(uart_if.tx_valid), 1);
    chk({name, ".tx_data"},    32'(uart_if.tx_data),  32'(reply));
    chk({name, ".cfg_update"}, 32'(cfg_update),       32'(!busy_last));
    chk_cfg(name);
    tick();
    chk({name, ".after"}, 32'({uart_if.tx_valid, cfg_update}), 0);
    chk_cfg({name, ".hold"});
  endtask

  initial begin
    rst = 1'b1;
    uart_if.rx_valid = 1'b0; uart_if.rx_data = 8'h00; uart_if.tx_ready = 1'b1;
    scope_busy = 1'b0; scope_triggered = 1'b0; scope_done = 1'b0;
    ref_reset();
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    vecs[0] = '{8'h41, 1'b0, 1'b0, 1'b0, ACK,   1'b1, 1'b0};
    vecs[1] = '{8'h41, 1'b1, 1'b0, 1'b0, NAK,   1'b0, 1'b0};
    vecs[2] = '{8'h58, 1'b1, 1'b0, 1'b0, ACK,   1'b0, 1'b1};
    vecs[3] = '{8'h58, 1'b0, 1'b1, 1'b1, ACK,   1'b0, 1'b1};
    vecs[4] = '{8'h53, 1'b1, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0};
    vecs[5] = '{8'h53, 1'b0, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0};
    vecs[6] = '{8'h53, 1'b1, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 1'b0, 1'b0, 1'b0, NAK,   1'b0, 1'b0};
    vecs[8] = '{8'hFF, 1'b0, 1'b0, 1'b0, NAK,   1'b0, 1'b0};
    vecs[9] = '{8'h61, 1'b0, 1'b0, 1'b0, NAK,   1'b0, 1'b0};
    for (int v = 0; v < 10; v++)
      single_cmd($sformatf("vec%0d", v), vecs[v].op, vecs[v].busy, vecs[v].trig,
                 vecs[v].done, vecs[v].reply, vecs[v].exp_arm, vecs[v].exp_abort);

    // Rising config with the reference payload, then falling config refused while busy.
    pl = '{8'h34, 8'h12, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h04, 8'h00, 8'h00};
    cfg_cmd("cfg_rise", 8'h52, 1'b0, 0);
    chk("cfg_rise.level_lit", 32'(cfg_level), 32'h1234);
    chk("cfg_rise.pre_lit",   cfg_pretrig,    32'h12345678);
    chk("cfg_rise.post_lit",  cfg_posttrig,   32'h00000400);
    pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44};
    cfg_cmd("cfg_fall_busy", 8'h46, 1'b1, 1);

    // Timeout after four payload bytes.
    send(8'h52);
    for (int i = 0; i < 4; i++) send(8'h5A);
    cnt = 1;
    while (!uart_if.tx_valid && cnt < 300) begin
      tick();
      cnt++;
    end
    chk("timeout.cycles",  32'(cnt), TMO);
    chk("timeout.tx_data", 32'(uart_if.tx_data), 32'(NAK));
    chk("timeout.no_upd",  32'(cfg_update), 0);
    chk_cfg("timeout");
    tick();
    single_cmd("timeout.status", 8'h53, 1'b0, 1'b1, 1'b1, 8'h06, 1'b0, 1'b0);

    // Reply held while the transmitter stalls; an injected arm opcode is dropped.
    uart_if.tx_ready = 1'b0;
    scope_busy = 1'b1; scope_triggered = 1'b1; scope_done = 1'b0;
    send(8'h53);
    for (int c = 0; c < 50; c++) begin
      chk("stall.tx_valid", 32'(uart_if.tx_valid), 1);
      chk("stall.tx_data",  32'(uart_if.tx_data),  32'h03);
      chk("stall.arm",      32'(arm), 0);
      if (c == 10) begin
        scope_busy = 1'b0;
        send(8'h41);
      end else begin
        tick();
      end
    end
    uart_if.tx_ready = 1'b1;
    tick();
    chk("stall.release", 32'({uart_if.tx_valid, arm}), 0);
    single_cmd("stall.next_arm", 8'h41, 1'b0, 1'b0, 1'b0, ACK, 1'b1, 1'b0);

    // Reset mid-payload, then reset while a reply is pending.
    send(8'h46);
    for (int i = 0; i < 6; i++) send(8'h99);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ref_reset();
    chk_reset_outputs("rst_payload");
    single_cmd("rst_payload.abort", 8'h58, 1'b0, 1'b0, 1'b0, ACK, 1'b0, 1'b1);
    uart_if.tx_ready = 1'b0;
    send(8'h41);
    chk("rst_resp.pending", 32'({uart_if.tx_valid, arm}), 32'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    uart_if.tx_ready = 1'b1;
    chk_reset_outputs("rst_resp");
    single_cmd("rst_resp.abort", 8'h58, 1'b1, 1'b0, 1'b0, ACK, 1'b0, 1'b1);

    // Random command stream against the reference model.
    for (int n = 0; n < 200; n++) begin
      int          kind;
      logic [7:0]  op;
      logic        b, t, d;
      kind = $urandom_range(0, 5);
      b = 1'($urandom_range(0, 1));
      t = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
      if (kind >= 4) begin
        for (int i = 0; i < 10; i++) pl[i] = 8'($urandom);
        cfg_cmd($sformatf("rnd%0d.cfg", n), (kind == 4) ? 8'h52 : 8'h46, b, 3);
      end else begin
        case (kind)
          0:       op = 8'h41;
          1:       op = 8'h58;
          2:       op = 8'h53;
          default: op = 8'($urandom);
        endcase
        if (op == 8'h52 || op == 8'h46) op = 8'h00;
        single_cmd($sformatf("rnd%0d.op%02h", n, op), op, b, t, d, ref_reply(op, b, t, d),
                   (op == 8'h41) && !b, op == 8'h58);
        chk_cfg($sformatf("rnd%0d.cfg_keep", n));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/scope_cmd_ctrl.md
# scope_cmd_ctrl

UART command sequencer for the ADC scope capture path. It parses opcode and payload bytes from the RS-232 receiver and loads the trigger and capture configuration registers. It issues arm and abort strobes to the capture engine and returns a one-byte acknowledge or status reply through the RS-232 transmitter. It sits in soc_top between the UART byte interfaces and the scope capture/trigger logic.

## Interface
- TIMEOUT_CYCLES, 1000000, maximum clk cycles allowed between payload bytes; 10 ms at 100 MHz
- PAYLOAD_BYTES, 10, payload length of trigger-config commands; fixed by the field map below
- clk  in  1  system clock, the single clock domain
- rst  in  1  reset, synchronous, active-high
- rx_valid  in  1  one-cycle strobe; rx_data holds a received byte; no backpressure
- rx_data  in  8  received byte
- tx_valid  out  1  reply byte valid; held until tx_ready
- tx_data  out  8  reply byte; stable while tx_valid
- tx_ready  in  1  transmitter accepts tx_data when tx_valid && tx_ready
- scope_busy  in  1  capture engine armed or capturing
- scope_triggered  in  1  trigger seen in the current capture
- scope_done  in  1  capture complete, data available
- arm  out  1  one-cycle arm strobe
- abort  out  1  one-cycle abort strobe
- cfg_update  out  1  one-cycle strobe; the cfg_* registers hold new values
- cfg_edge  out  1  trigger edge: 1 = rising, 0 = falling
- cfg_level  out  16  trigger level
- cfg_pretrig  out  32  pre-trigger sample count
- cfg_posttrig  out  32  post-trigger sample count

## Operation
- States: IDLE, PAYLOAD, RESP.
- Opcodes, accepted only in IDLE:
  - 0x41 'A' arm: if !scope_busy, pulse arm and reply ACK 0x06; otherwise reply NAK 0x15.
  - 0x52 'R' / 0x46 'F' rising/falling trigger config: enter PAYLOAD, clear the byte index, latch the edge into a shadow register.
  - 0x58 'X' abort: pulse abort, reply ACK.
  - 0x53 'S' status: reply {5'b0, scope_done, scope_triggered, scope_busy}, sampled in the opcode cycle.
  - Any other opcode: reply NAK.
- PAYLOAD field map: bytes 0-1 are level, bytes 2-5 are pretrig, bytes 6-9 are posttrig. All fields are little-endian. Bytes are collected into shadow registers.
- On byte 9:
  - If !scope_busy: copy the shadow registers to cfg_* and pulse cfg_update; reply ACK.
  - If scope_busy: reply NAK; cfg_* stay unchanged.
- Timeout counter:
  - Reloads on entry to PAYLOAD and on each payload byte.
  - If it reaches TIMEOUT_CYCLES with no byte: discard the shadow registers, reply NAK, leave cfg_* unchanged.
- RESP: tx_valid=1 until tx_ready; then return to IDLE.
  - rx bytes arriving in RESP are dropped. The host waits for the reply before sending the next command.
- Reset values: tx_valid=0, tx_data=0, arm=abort=cfg_update=0, cfg_edge=1, cfg_level=16'h2000, cfg_pretrig=0, cfg_posttrig=32'd1024; state IDLE, byte index 0.

## Timing
- Opcode byte in cycle N (rx_valid=1):
  - arm/abort pulse in cycle N+1.
  - tx_valid rises in cycle N+1 with the reply byte.
- Last payload byte in cycle M:
  - cfg_* take their new values in cycle M+1, together with the cfg_update pulse and tx_valid.
  - cfg_* change only on the cfg_update cycle.
- Timeout: fires when TIMEOUT_CYCLES cycles have elapsed after the last accepted byte with no new byte. tx_valid=NAK in the following cycle.
- Handshake: the transfer completes in the cycle where tx_valid && tx_ready. The FSM is in IDLE in the next cycle, and tx_valid=0.
  - If tx_ready is already high when tx_valid rises, the reply occupies exactly one cycle.
- scope_busy is sampled in the same cycle as the deciding byte (opcode for 'A', byte 9 for 'R'/'F').
- rst asserted in any state, including mid-payload and RESP:
  - Next cycle: all outputs at their reset values.
  - The pending reply and partial payload are discarded.
  - Strobes are never extended across reset.
- Byte index wraps never: the count is bounded to 0..9 and leaves PAYLOAD on byte 9.

## Test plan
- Reset, then rx 0x41 with scope_busy=0 -> arm pulse 1 cycle at N+1; tx_data=0x06; second 0x41 with scope_busy=1 -> no arm, tx_data=0x15.
- rx 0x52 followed by 34 12 78 56 34 12 00 04 00 00 -> after the last byte:
  - cfg_edge=1, cfg_level=0x1234, cfg_pretrig=0x12345678, cfg_posttrig=0x00000400.
  - cfg_update for 1 cycle, reply 0x06.
- rx 0x46 plus 10 bytes with scope_busy=1 at the last byte -> reply 0x15; cfg_* and cfg_edge unchanged; no cfg_update.
- rx 0x52 plus 4 bytes, then silence (TIMEOUT_CYCLES=100 in bench) -> NAK 0x15 exactly 100 cycles after the 4th byte; the next 0x53 gets a status reply, proving the FSM is in IDLE.
- Hold tx_ready=0 for 50 cycles after 0x53 (busy=1, triggered=1, done=0):
  - tx_valid held with tx_data=0x03 throughout.
  - A 0x41 injected in this window is dropped: no arm.
- Assert rst mid-payload (after byte 5) and during RESP -> outputs return to reset values; subsequent 0x58 -> abort pulse, ACK 0x06.
